// File: rtl/midi_voice_allocator_if.sv
// Note-event handshake from the MIDI parser plus the voice-bank gate/period bus.
interface midi_voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  logic                  ev_valid;
  logic                  ev_ready;
  logic [7:0]            ev_note;
  logic [7:0]            ev_velocity;
  logic [NUM_VOICES-1:0] v_load;
  logic [24:0]           v_period;
  logic [NUM_VOICES-1:0] v_gate;
  logic                  ev_dropped;

  modport master (output ev_valid, ev_note, ev_velocity,
                  input  ev_ready, v_load, v_period, v_gate, ev_dropped);
  modport slave  (input  ev_valid, ev_note, ev_velocity,
                  output ev_ready, v_load, v_period, v_gate, ev_dropped);
endinterface

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: IDLE/SCAN/COMMIT scheduler over NUM_VOICES square-wave voices.
// Optional macro VOICE_STEAL_EN: steal the oldest gated voice when every voice is sounding.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input logic                   clk,
  input logic                   rst,
  midi_voice_allocator_if.slave bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_e;
  typedef enum logic [1:0] {ACT_NONE = 2'd0, ACT_ON = 2'd1, ACT_OFF = 2'd2} act_e;

  // Equal-tempered period: octave found by repeated subtraction of 12, no divider.
  function automatic logic [24:0] note_period(input logic [6:0] note);
    logic [6:0]  rem;
    logic [3:0]  oct;
    logic [24:0] base;
    rem = note;
    oct = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (rem >= 7'd12) begin
        rem = rem - 7'd12;
        oct = oct + 4'd1;
      end
    end
    case (rem)
      7'd0:    base = 25'd91736;
      7'd1:    base = 25'd86587;
      7'd2:    base = 25'd81728;
      7'd3:    base = 25'd77141;
      7'd4:    base = 25'd72811;
      7'd5:    base = 25'd68724;
      7'd6:    base = 25'd64867;
      7'd7:    base = 25'd61227;
      7'd8:    base = 25'd57790;
      7'd9:    base = 25'd54547;
      7'd10:   base = 25'd51485;
      7'd11:   base = 25'd48596;
      default: base = 25'd0;
    endcase
    if (oct < 4'd4) note_period = base << (4'd4 - oct);
    else            note_period = base >> (oct - 4'd4);
  endfunction

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [7:0]            ev_note_q, ev_note_d;
  logic                  note_on_q, note_on_d;
  logic                  match_found_q, match_found_d;
  logic [IDX_W-1:0]      match_idx_q, match_idx_d;
  logic                  free_found_q, free_found_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;
`ifdef VOICE_STEAL_EN
  logic                  old_found_q, old_found_d;
  logic [IDX_W-1:0]      old_idx_q, old_idx_d;
  logic [AGE_W-1:0]      old_age_q, old_age_d;
`endif
  act_e                  act_q, act_d;
  logic [IDX_W-1:0]      tgt_q, tgt_d;
  logic                  ev_ready_q, ev_ready_d;
  logic [NUM_VOICES-1:0] v_load_q, v_load_d;
  logic [24:0]           v_period_q, v_period_d;
  logic                  ev_dropped_q, ev_dropped_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];

  assign bus.ev_ready   = ev_ready_q;
  assign bus.v_load     = v_load_q;
  assign bus.v_period   = v_period_q;
  assign bus.v_gate     = gate_q;
  assign bus.ev_dropped = ev_dropped_q;

  // Scheduler next state; the last SCAN step folds in the final voice and decides.
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    ev_note_d     = ev_note_q;
    note_on_d     = note_on_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
`ifdef VOICE_STEAL_EN
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
`endif
    act_d         = act_q;
    tgt_d         = tgt_q;
    v_load_d      = {NUM_VOICES{1'b0}};
    v_period_d    = 25'd0;
    ev_dropped_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ev_valid && ev_ready_q) begin
          ev_note_d     = bus.ev_note;
          note_on_d     = |bus.ev_velocity;
          scan_idx_d    = {IDX_W{1'b0}};
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
`ifdef VOICE_STEAL_EN
          old_found_d   = 1'b0;
`endif
          state_d       = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!match_found_q && gate_q[scan_idx_q] && (note_q[scan_idx_q] == ev_note_q[6:0])) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end else begin
          match_found_d = match_found_q;
        end
        if (!free_found_q && !gate_q[scan_idx_q]) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end else begin
          free_found_d = free_found_q;
        end
`ifdef VOICE_STEAL_EN
        // Strict greater-than keeps the lowest index on equal ages.
        if (gate_q[scan_idx_q] && (!old_found_q || (age_q[scan_idx_q] > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = scan_idx_q;
          old_age_d   = age_q[scan_idx_q];
        end else begin
          old_found_d = old_found_q;
        end
`endif
        if (scan_idx_q == LAST_IDX) begin
          state_d = COMMIT;
          act_d   = ACT_NONE;
          tgt_d   = {IDX_W{1'b0}};
          if (ev_note_q[7]) begin
            ev_dropped_d = 1'b1;
          end else if (!note_on_q) begin
            if (match_found_d) begin
              act_d = ACT_OFF;
              tgt_d = match_idx_d;
            end else begin
              ev_dropped_d = 1'b1;
            end
          end else if (match_found_d) begin
            act_d = ACT_ON;
            tgt_d = match_idx_d;
          end else if (free_found_d) begin
            act_d = ACT_ON;
            tgt_d = free_idx_d;
          end else begin
`ifdef VOICE_STEAL_EN
            act_d = ACT_ON;
            tgt_d = old_idx_d;
`else
            ev_dropped_d = 1'b1;
`endif
          end
          if (act_d == ACT_ON) begin
            v_load_d   = {{(NUM_VOICES-1){1'b0}}, 1'b1} << tgt_d;
            v_period_d = note_period(ev_note_q[6:0]);
          end else begin
            v_load_d   = {NUM_VOICES{1'b0}};
            v_period_d = 25'd0;
          end
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ev_ready_d = (state_d == IDLE);
  end

  // Voice state update applied on the edge that ends COMMIT.
  always_comb begin
    gate_d = gate_q;
    note_d = note_q;
    age_d  = age_q;
    if (state_q == COMMIT) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (act_q == ACT_ON) begin
          if (tgt_q == IDX_W'(i)) begin
            note_d[i] = ev_note_q[6:0];
            gate_d[i] = 1'b1;
            age_d[i]  = {AGE_W{1'b0}};
          end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end else begin
            age_d[i] = age_q[i];
          end
        end else if ((act_q == ACT_OFF) && (tgt_q == IDX_W'(i))) begin
          gate_d[i] = 1'b0;
        end else begin
          gate_d[i] = gate_q[i];
        end
      end
    end else begin
      gate_d = gate_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      scan_idx_q    <= {IDX_W{1'b0}};
      ev_note_q     <= 8'd0;
      note_on_q     <= 1'b0;
      match_found_q <= 1'b0;
      match_idx_q   <= {IDX_W{1'b0}};
      free_found_q  <= 1'b0;
      free_idx_q    <= {IDX_W{1'b0}};
`ifdef VOICE_STEAL_EN
      old_found_q   <= 1'b0;
      old_idx_q     <= {IDX_W{1'b0}};
      old_age_q     <= {AGE_W{1'b0}};
`endif
      act_q         <= ACT_NONE;
      tgt_q         <= {IDX_W{1'b0}};
      ev_ready_q    <= 1'b1;
      v_load_q      <= {NUM_VOICES{1'b0}};
      v_period_q    <= 25'd0;
      ev_dropped_q  <= 1'b0;
      gate_q        <= {NUM_VOICES{1'b0}};
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= 7'd0;
        age_q[i]  <= {AGE_W{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      ev_note_q     <= ev_note_d;
      note_on_q     <= note_on_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
`ifdef VOICE_STEAL_EN
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
`endif
      act_q         <= act_d;
      tgt_q         <= tgt_d;
      ev_ready_q    <= ev_ready_d;
      v_load_q      <= v_load_d;
      v_period_q    <= v_period_d;
      ev_dropped_q  <= ev_dropped_d;
      gate_q        <= gate_d;
      note_q        <= note_d;
      age_q         <= age_d;
    end
  end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator; expectations follow the build's VOICE_STEAL_EN setting.
module tb_midi_voice_allocator;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_seen;
  int   n_checks = 0;
  int   n_pass   = 0;

  midi_voice_allocator_if #(.NUM_VOICES(NV)) bus ();

  midi_voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (|bus.v_load) load_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    bus.ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One event: accept at cycle 0, COMMIT outputs at cycle 5, settled state at cycle 6.
  task automatic do_event(input string tag, input logic [7:0] note, input logic [7:0] vel,
                          input bit hold, input logic [3:0] exp_load,
                          input logic [24:0] exp_period, input logic exp_drop,
                          input logic [3:0] exp_gate);
    int waited = 0;
    @(negedge clk);
    while (bus.ev_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".ready0"}, 32'(bus.ev_ready), 32'd1);
    bus.ev_note     = note;
    bus.ev_velocity = vel;
    bus.ev_valid    = 1'b1;
    @(negedge clk);
    if (!hold) bus.ev_valid = 1'b0;
    chk({tag, ".busy"}, 32'(bus.ev_ready), 32'd0);
    repeat (4) @(negedge clk);
    bus.ev_valid = 1'b0;
    chk({tag, ".load"}, 32'(bus.v_load), 32'(exp_load));
    if (exp_load != 4'd0) chk({tag, ".period"}, 32'(bus.v_period), 32'(exp_period));
    chk({tag, ".drop"}, 32'(bus.ev_dropped), 32'(exp_drop));
    @(negedge clk);
    chk({tag, ".ready6"}, 32'(bus.ev_ready), 32'd1);
    chk({tag, ".gate"}, 32'(bus.v_gate), 32'(exp_gate));
    chk({tag, ".load6"}, 32'(bus.v_load), 32'd0);
    chk({tag, ".period6"}, 32'(bus.v_period), 32'd0);
    chk({tag, ".drop6"}, 32'(bus.ev_dropped), 32'd0);
  endtask

  initial begin
    bus.ev_valid    = 1'b0;
    bus.ev_note     = 8'd0;
    bus.ev_velocity = 8'd0;
    load_seen       = 1'b0;
    reset_dut();
    @(negedge clk);
    chk("rst.ready",  32'(bus.ev_ready),   32'd1);
    chk("rst.load",   32'(bus.v_load),     32'd0);
    chk("rst.period", 32'(bus.v_period),   32'd0);
    chk("rst.gate",   32'(bus.v_gate),     32'd0);
    chk("rst.drop",   32'(bus.ev_dropped), 32'd0);

    // Period table corners and sequential free-voice assignment
    do_event("on48",  8'd48,  8'd64, 1'b0, 4'b0001, 25'd91736,   1'b0, 4'b0001);
    do_event("on0",   8'd0,   8'd64, 1'b0, 4'b0010, 25'd1467776, 1'b0, 4'b0011);
    do_event("on127", 8'd127, 8'd64, 1'b0, 4'b0100, 25'd956,     1'b0, 4'b0111);

    // Fill all voices, then one and two more note-ons
    reset_dut();
    do_event("on60", 8'd60, 8'd100, 1'b0, 4'b0001, 25'd45868, 1'b0, 4'b0001);
    do_event("on62", 8'd62, 8'd100, 1'b0, 4'b0010, 25'd40864, 1'b0, 4'b0011);
    do_event("on64", 8'd64, 8'd100, 1'b0, 4'b0100, 25'd36405, 1'b0, 4'b0111);
    do_event("on65", 8'd65, 8'd100, 1'b0, 4'b1000, 25'd34362, 1'b0, 4'b1111);
`ifdef VOICE_STEAL_EN
    do_event("steal67", 8'd67, 8'd100, 1'b0, 4'b0001, 25'd30613, 1'b0, 4'b1111);
    do_event("steal69", 8'd69, 8'd100, 1'b0, 4'b0010, 25'd27273, 1'b0, 4'b1111);
`else
    do_event("full67", 8'd67, 8'd100, 1'b0, 4'b0000, 25'd0, 1'b1, 4'b1111);
    do_event("full69", 8'd69, 8'd100, 1'b0, 4'b0000, 25'd0, 1'b1, 4'b1111);
`endif

    // Retrigger, note-off, unmatched note-off
    reset_dut();
    do_event("re60a",  8'd60, 8'd90, 1'b0, 4'b0001, 25'd45868, 1'b0, 4'b0001);
    do_event("re60b",  8'd60, 8'd90, 1'b0, 4'b0001, 25'd45868, 1'b0, 4'b0001);
    do_event("off60",  8'd60, 8'd0,  1'b0, 4'b0000, 25'd0,     1'b0, 4'b0000);
    do_event("off61",  8'd61, 8'd0,  1'b0, 4'b0000, 25'd0,     1'b1, 4'b0000);
    do_event("on62b",  8'd62, 8'd90, 1'b0, 4'b0001, 25'd40864, 1'b0, 4'b0001);
    do_event("on64b",  8'd64, 8'd90, 1'b0, 4'b0010, 25'd36405, 1'b0, 4'b0011);
    do_event("re62",   8'd62, 8'd90, 1'b0, 4'b0001, 25'd40864, 1'b0, 4'b0011);
    do_event("off64",  8'd64, 8'd0,  1'b0, 4'b0000, 25'd0,     1'b0, 4'b0001);

    // Out-of-range note held valid through the busy window
    do_event("n200", 8'd200, 8'd50, 1'b1, 4'b0000, 25'd0, 1'b1, 4'b0001);

    // Reset in the middle of SCAN
    @(negedge clk);
    load_seen       = 1'b0;
    bus.ev_note     = 8'd50;
    bus.ev_velocity = 8'd70;
    bus.ev_valid    = 1'b1;
    @(negedge clk);
    bus.ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.ready", 32'(bus.ev_ready), 32'd1);
    chk("midrst.gate",  32'(bus.v_gate),   32'd0);
    chk("midrst.load",  32'(bus.v_load),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst.noload", 32'(load_seen),   32'd0);
    chk("midrst.gate2",  32'(bus.v_gate),  32'd0);
    chk("midrst.ready2", 32'(bus.ev_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
